// File: rtl/seg_mux_shift_driver.sv
// seg_mux_shift_driver: multiplexed seven-segment driver for a serial-in /
// parallel-out shift-register chain. Each frame is {one-hot select, dp+gfedcba},
// shifted MSB first with its own data clock and latch strobe. Digits are scanned
// round-robin; digit 0's LOAD snapshots the value so a scan never tears.
// Optional feature: define SEG_MUX_LEADING_ZERO_BLANK_EN to blank leading zeros.
module seg_mux_shift_driver #(
    parameter int NUM_DIGITS   = 3,
    parameter int SEL_WIDTH    = 8,
    parameter int CLK_DIV      = 4,
    parameter int DWELL_CYCLES = 1024
) (
    input  logic                    i_clk,
    input  logic                    i_reset_n,
    input  logic                    i_enable,
    input  logic [4*NUM_DIGITS-1:0] i_value,
    input  logic [NUM_DIGITS-1:0]   i_dp,
    output logic                    o_data_val,
    output logic                    o_data_clock,
    output logic                    o_latch_shifted_value,
    output logic [2:0]              o_digit_index,
    output logic                    o_busy,
    output logic                    o_frame_done
);

    localparam int FW    = SEL_WIDTH + 8;
    localparam int VW    = 4 * NUM_DIGITS;
    localparam int P_MIN = 2 + FW * 2 * CLK_DIV + CLK_DIV;
    localparam int CNT_W = $clog2(DWELL_CYCLES + P_MIN + 1);
    localparam int DIV_W = $clog2(2 * CLK_DIV);
    localparam int BIT_W = $clog2(FW);

    typedef enum logic [2:0] {IDLE, LOAD, SHIFT, LATCH, DWELL} state_t;

    state_t            state, state_nxt;
    logic [DIV_W-1:0]  div;
    logic [BIT_W-1:0]  bit_cnt;
    logic [CNT_W-1:0]  dwell_cnt;
    logic [2:0]        idx;
    logic [VW-1:0]     snap_val;
    logic [NUM_DIGITS-1:0] snap_dp;
    logic [FW-1:0]     sr;

    logic [VW-1:0]         cur_val;
    logic [NUM_DIGITS-1:0] cur_dp;
    logic [3:0]            nib;
    logic                  dp_bit;
    logic [7:0]            seg;
    logic [SEL_WIDTH-1:0]  sel;
    logic [FW-1:0]         frame;

    logic div_last, latch_last, bit_last, dwell_exit;

    assign div_last   = (div == DIV_W'(2 * CLK_DIV - 1));
    assign latch_last = (div == DIV_W'(CLK_DIV - 1));
    assign bit_last   = (bit_cnt == BIT_W'(FW - 1));
    // The dwell counter can run past DWELL_CYCLES-1 when the frame itself is longer.
    assign dwell_exit = (dwell_cnt >= CNT_W'(DWELL_CYCLES - 1));

    // Active-high gfedcba pattern for one hex nibble.
    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: return 7'h3F;
            4'h1: return 7'h06;
            4'h2: return 7'h5B;
            4'h3: return 7'h4F;
            4'h4: return 7'h66;
            4'h5: return 7'h6D;
            4'h6: return 7'h7D;
            4'h7: return 7'h07;
            4'h8: return 7'h7F;
            4'h9: return 7'h6F;
            4'hA: return 7'h77;
            4'hB: return 7'h7C;
            4'hC: return 7'h39;
            4'hD: return 7'h5E;
            4'hE: return 7'h79;
            default: return 7'h71;
        endcase
    endfunction

    // State register.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) state <= IDLE;
        else            state <= state_nxt;
    end

    // Next-state logic; a started frame always runs through LATCH and DWELL.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (i_enable) state_nxt = LOAD;
            LOAD:    state_nxt = SHIFT;
            SHIFT:   if (div_last && bit_last) state_nxt = LATCH;
            LATCH:   if (latch_last) state_nxt = DWELL;
            DWELL:   if (dwell_exit) state_nxt = i_enable ? LOAD : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Frame builder; digit 0 reads live inputs since its LOAD takes the snapshot.
    always_comb begin
        cur_val = (idx == 3'd0) ? i_value : snap_val;
        cur_dp  = (idx == 3'd0) ? i_dp    : snap_dp;
        nib     = 4'(cur_val >> {idx, 2'b00});
        dp_bit  = 1'(cur_dp >> idx);
        seg     = {dp_bit, hex7(nib)};
`ifdef SEG_MUX_LEADING_ZERO_BLANK_EN
        if (idx != 3'd0 && !dp_bit && (cur_val >> {idx, 2'b00}) == '0)
            seg = 8'h00;
`endif
        sel   = {{(SEL_WIDTH-1){1'b0}}, 1'b1} << idx;
        frame = {sel, seg};
    end

    // Datapath: dwell timer, bit-period divider, shift register, snapshot, digit index.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            dwell_cnt <= '0;
            div       <= '0;
            bit_cnt   <= '0;
            sr        <= '0;
            snap_val  <= '0;
            snap_dp   <= '0;
            idx       <= '0;
        end else begin
            if (state == IDLE || state_nxt == LOAD) dwell_cnt <= '0;
            else                                    dwell_cnt <= dwell_cnt + CNT_W'(1);

            if ((state == SHIFT || state == LATCH) && state_nxt == state && !div_last)
                div <= div + DIV_W'(1);
            else
                div <= '0;

            if (state == LOAD) begin
                sr      <= frame;
                bit_cnt <= '0;
                if (idx == 3'd0) begin
                    snap_val <= i_value;
                    snap_dp  <= i_dp;
                end
            end else if (state == SHIFT && div_last) begin
                sr      <= {sr[FW-2:0], 1'b0};
                bit_cnt <= bit_cnt + BIT_W'(1);
            end

            if (state == DWELL && dwell_exit) begin
                if (!i_enable || idx == 3'(NUM_DIGITS - 1)) idx <= '0;
                else                                        idx <= idx + 3'd1;
            end
        end
    end

    assign o_data_val            = (state == SHIFT) && sr[FW-1];
    assign o_data_clock          = (state == SHIFT) && (div >= DIV_W'(CLK_DIV));
    assign o_latch_shifted_value = (state == LATCH);
    assign o_frame_done          = (state == LATCH) && latch_last;
    assign o_busy                = (state != IDLE);
    assign o_digit_index         = idx;

endmodule

// File: tb/tb_seg_mux_shift_driver.sv
// Directed bench for seg_mux_shift_driver: a 16-bit shift-register model
// captures each latched frame, compared against hand-decoded constants.
module tb_seg_mux_shift_driver;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en_a = 1'b0, en_b = 1'b0;
    logic [11:0] val_a = 12'h1A3, val_b = 12'h005;
    logic [2:0]  dp_a = 3'b000, dp_b = 3'b000;

    logic       da, ca, la, ba, fa;
    logic [2:0] ia;
    logic       db, cb, lb, bb, fb;
    logic [2:0] ib;

    seg_mux_shift_driver #(.NUM_DIGITS(3), .SEL_WIDTH(8), .CLK_DIV(2), .DWELL_CYCLES(100)) dut_a (
        .i_clk(clk), .i_reset_n(rst_n), .i_enable(en_a), .i_value(val_a), .i_dp(dp_a),
        .o_data_val(da), .o_data_clock(ca), .o_latch_shifted_value(la),
        .o_digit_index(ia), .o_busy(ba), .o_frame_done(fa));

    seg_mux_shift_driver #(.NUM_DIGITS(3), .SEL_WIDTH(8), .CLK_DIV(2), .DWELL_CYCLES(10)) dut_b (
        .i_clk(clk), .i_reset_n(rst_n), .i_enable(en_b), .i_value(val_b), .i_dp(dp_b),
        .o_data_val(db), .o_data_clock(cb), .o_latch_shifted_value(lb),
        .o_digit_index(ib), .o_busy(bb), .o_frame_done(fb));

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    // External shift-register chain models.
    logic [15:0] chain_a = '0, lat_a = '0, chain_b = '0, lat_b = '0;
    int nlat_a = 0, lat_cyc_a = 0, prev_cyc_a = 0, busy_cyc_a = 0, done_cyc_a = 0;
    int nlat_b = 0, lat_cyc_b = 0, prev_cyc_b = 0;
    logic [2:0] lat_idx_a = '0;

    always @(posedge ca) chain_a = {chain_a[14:0], da};
    always @(posedge la) begin
        lat_a = chain_a; prev_cyc_a = lat_cyc_a; lat_cyc_a = cyc; lat_idx_a = ia; nlat_a++;
    end
    always @(posedge ba) busy_cyc_a = cyc;
    always @(posedge fa) done_cyc_a = cyc;

    always @(posedge cb) chain_b = {chain_b[14:0], db};
    always @(posedge lb) begin
        lat_b = chain_b; prev_cyc_b = lat_cyc_b; lat_cyc_b = cyc; nlat_b++;
    end

    int checks = 0, errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Wait (bounded) for the next latch pulse of instance A or B.
    task automatic wait_lat(input bit sel_b, input string tag);
        int n0 = sel_b ? nlat_b : nlat_a;
        int k = 0;
        while (((sel_b ? nlat_b : nlat_a) == n0) && k < 300) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_seen"}, ((sel_b ? nlat_b : nlat_a) != n0), 1);
    endtask

    initial begin
        int k;
        int saved;

        repeat (3) @(negedge clk);
        chk("reset_outs", {da, ca, la, ba, fa, ia}, 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_busy", ba, 0);

        // Basic scan 1A3.
        en_a = 1'b1;
        wait_lat(0, "s0d0"); chk("s0d0", lat_a, 16'h014F);
        chk("load_to_latch", lat_cyc_a - busy_cyc_a, 65);
        chk("lat_idx0", lat_idx_a, 0);
        repeat (2) @(negedge clk);
        chk("done_offset", done_cyc_a - lat_cyc_a, 1);
        wait_lat(0, "s0d1"); chk("s0d1", lat_a, 16'h0277);
        chk("period_100", lat_cyc_a - prev_cyc_a, 100);
        chk("lat_idx1", lat_idx_a, 1);
        wait_lat(0, "s0d2"); chk("s0d2", lat_a, 16'h0406);
        chk("lat_idx2", lat_idx_a, 2);
        wait_lat(0, "s1d0"); chk("s1d0_wrap", lat_a, 16'h014F);

        // dp change mid-scan is only picked up at the next digit-0 LOAD.
        dp_a = 3'b010;
        wait_lat(0, "s1d1"); chk("s1d1_olddp", lat_a, 16'h0277);
        wait_lat(0, "s1d2"); chk("s1d2", lat_a, 16'h0406);
        wait_lat(0, "s2d0"); chk("s2d0", lat_a, 16'h014F);
        val_a = 12'hFFF;
        wait_lat(0, "s2d1"); chk("s2d1_snap", lat_a, 16'h02F7);
        wait_lat(0, "s2d2"); chk("s2d2_snap", lat_a, 16'h0406);
        wait_lat(0, "s3d0"); chk("s3d0_fff", lat_a, 16'h0171);
        wait_lat(0, "s3d1"); chk("s3d1_fff", lat_a, 16'h02F1);
        wait_lat(0, "s3d2"); chk("s3d2_fff", lat_a, 16'h0471);

        // Enable drop in the middle of the digit-0 shift.
        val_a = 12'h1A3; dp_a = 3'b000;
        repeat (40) @(negedge clk);
        chk("mid_shift_busy", ba, 1);
        en_a = 1'b0;
        wait_lat(0, "drop"); chk("drop_frame", lat_a, 16'h014F);
        k = 0;
        while (ba && k < 200) begin @(negedge clk); k++; end
        chk("idle_after_drop", {ba, ia}, 0);
        saved = nlat_a;
        repeat (150) @(negedge clk);
        chk("no_frame_idle", nlat_a, saved);
        en_a = 1'b1;
        wait_lat(0, "reen"); chk("reen_d0", lat_a, 16'h014F);
        chk("reen_idx", lat_idx_a, 0);

        // Async reset mid-shift of digit 1, between clock edges.
        repeat (50) @(negedge clk);
        chk("pre_reset_state", {ba, ia}, {1'b1, 3'd1});
        #2 rst_n = 1'b0;
        #1 chk("reset_async_outs", {da, ca, la, ba, fa, ia}, 0);
        saved = nlat_a;
        repeat (3) @(negedge clk);
        chk("no_latch_on_reset", nlat_a, saved);
        rst_n = 1'b1;
        wait_lat(0, "post_rst"); chk("post_rst_d0", lat_a, 16'h014F);
        chk("post_rst_timing", lat_cyc_a - busy_cyc_a, 65);

        // Short dwell, value 005 (blanking depends on build).
        en_b = 1'b1;
        wait_lat(1, "b_d0"); chk("b_d0", lat_b, 16'h016D);
`ifdef SEG_MUX_LEADING_ZERO_BLANK_EN
        wait_lat(1, "b_d1"); chk("b_d1", lat_b, 16'h0200);
        chk("b_period1", lat_cyc_b - prev_cyc_b, 68);
        wait_lat(1, "b_d2"); chk("b_d2", lat_b, 16'h0400);
`else
        wait_lat(1, "b_d1"); chk("b_d1", lat_b, 16'h023F);
        chk("b_period1", lat_cyc_b - prev_cyc_b, 68);
        wait_lat(1, "b_d2"); chk("b_d2", lat_b, 16'h043F);
`endif
        chk("b_period2", lat_cyc_b - prev_cyc_b, 68);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg_mux_shift_driver.md
# seg_mux_shift_driver

Parametrised multiplexed seven-segment display driver for boards whose digits are wired through a serial-in/parallel-out shift-register chain. Takes an N-digit hex value plus decimal-point mask, and scans the digits round-robin. For each digit it decodes the nibble, prepends a one-hot digit-select field, and shifts the frame out MSB first with its own data clock and latch strobe. Sits between the application counter logic in `top` and the board pins, replacing the separate decoder, one-hot encoder and shift-register instances with one self-timed block.

## Interface
- `NUM_DIGITS`, 3: digits scanned, 1..8.
- `SEL_WIDTH`, 8: digit-select field width, ≥ `NUM_DIGITS`.
- `CLK_DIV`, 4: `i_clk` cycles per shift-clock half period, ≥ 1.
- `DWELL_CYCLES`, 1024: cycles from one frame's LOAD to the next frame's LOAD.
- `i_clk` input 1: system clock, all logic on rising edge.
- `i_reset_n` input 1: asynchronous, active-low reset.
- `i_enable` input 1: scan enable.
- `i_value` input 4*`NUM_DIGITS`: hex digits; digit k = `i_value[4k+:4]`, digit 0 least significant.
- `i_dp` input `NUM_DIGITS`: decimal point per digit.
- `o_data_val` output 1: serial data to the shift-register DS pin.
- `o_data_clock` output 1: shift clock.
- `o_latch_shifted_value` output 1: storage-register latch.
- `o_digit_index` output 3: digit currently being shifted/shown.
- `o_busy` output 1: high in every state except IDLE.
- `o_frame_done` output 1: one-cycle pulse on the cycle the latch falls.

## Operation
- Frame width `FW = SEL_WIDTH + 8`. Frame = {select[SEL_WIDTH-1:0], seg[7:0]}.
  - select = one-hot of the digit index.
  - seg[7] = dp, seg[6:0] = g,f,e,d,c,b,a, active high.
  - Hex decode is standard 0-F (A,b,C,d,E,F shapes).
- States:
  - IDLE: outputs low. Go to LOAD when `i_enable`=1.
  - LOAD, 1 cycle:
    - If digit index = 0, snapshot `i_value`/`i_dp`. Digits 1..N-1 use that snapshot, so no tearing within a scan.
    - Build the frame into a FW-bit shift register.
    - Restart the dwell counter.
  - SHIFT:
    - `o_data_val` = frame MSB for the whole bit period.
    - `o_data_clock` is low for `CLK_DIV` cycles, then high for `CLK_DIV` cycles.
    - Shift left on the cycle the clock falls, after the high phase.
    - After FW bits, go to LATCH.
  - LATCH: `o_latch_shifted_value` high for `CLK_DIV` cycles with data and clock low. `o_frame_done` pulses on the last of these cycles. Then go to DWELL.
  - DWELL:
    - Wait until the dwell counter reaches `DWELL_CYCLES-1`. If it is already past that value, leave immediately.
    - On exit, advance the digit index, wrapping `NUM_DIGITS-1`→0.
    - If `i_enable`=0, go to IDLE (index reset to 0); otherwise go to LOAD.
- `i_enable` falling mid-frame: the current frame completes through LATCH and DWELL. It is never truncated.
- Reset (any state, mid-shift included):
  - All outputs go to 0 immediately: `o_data_val`, `o_data_clock`, `o_latch_shifted_value`, `o_busy`, `o_frame_done`, and `o_digit_index`=0.
  - State goes to IDLE; snapshot and shift register clear.
  - Partially shifted data is not latched.

## Timing
- `i_enable` sampled high in IDLE → LOAD on the next cycle. The first `o_data_clock` rise comes `CLK_DIV` cycles after SHIFT entry.
- SHIFT lasts `FW*2*CLK_DIV` cycles; LATCH lasts `CLK_DIV` cycles.
- Minimum frame period `P_min = 1 + FW*2*CLK_DIV + CLK_DIV + 1`. Actual period = max(`DWELL_CYCLES`, `P_min`).
- Full scan = `NUM_DIGITS` × period. A snapshot taken at a digit-0 LOAD is displayed for the whole scan.
- Data is stable ≥ `CLK_DIV` cycles before and after each `o_data_clock` rising edge.

## Configuration
- `SEG_MUX_LEADING_ZERO_BLANK_EN` defined: leading zeros are blanked.
  - Applies to digits `NUM_DIGITS-1` down to 1 whose snapshot nibble and all higher nibbles are 0 and whose dp is 0.
  - Blanked digits get seg = 8'h00, with the select bit still sent.
  - Digit 0 is never blanked.
- Macro undefined: every digit is decoded normally, so 0 shows 8'h3F.

## Test plan
- Basic scan: `NUM_DIGITS`=3, `SEL_WIDTH`=8, `CLK_DIV`=2, `DWELL_CYCLES`=100, `i_value`=12'h1A3, `i_dp`=0, enable held → latched frames 16'h014F, 16'h0277, 16'h0406, repeating. LATCH starts 65 cycles after each LOAD; LOADs are 100 cycles apart.
- Decimal point and snapshot: `i_dp`=3'b010; change `i_value` to 12'hFFF during digit 1 → digit 1 frame 16'h02F7 from the old snapshot; the next scan gives 16'h0171, 16'h02F1, 16'h0471.
- Leading-zero blanking: `i_value`=12'h005 → with macro: 16'h016D, 16'h0200, 16'h0400. Without macro: 16'h016D, 16'h023F, 16'h043F.
- Short dwell: `DWELL_CYCLES`=10 → period = `P_min` = 68 cycles, with no gaps.
- Enable drop mid-SHIFT → the frame still latches, then IDLE with `o_busy`=0 and index 0. Re-enable → digit 0 frame first.
- Async reset asserted mid-SHIFT, between clock edges → all outputs 0 in the same cycle, no latch pulse. After release with enable high → clean digit 0 frame.
